dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-cache access sequencer and MEM/WB register.
// Ports: CLK/nRST, EX/MEM slot in, dcache req/resp, stall, WB bundle, sticky flags.
module dmem_access_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid,
  input  logic        dmemREN_l,
  input  logic        dmemWEN_l,
  input  logic [31:0] aluout,
  input  logic [31:0] storedata,
  input  logic        hlt_l,
  input  logic        regen_l,
  input  logic [4:0]  wsel_l,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_regen,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_data,
  output logic        halt,
  output logic        err_align,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic        r_is_store;
  logic        r_regen;
  logic [4:0]  r_wsel;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_wb_valid;
  logic        r_wb_regen;
  logic [4:0]  r_wb_wsel;
  logic [31:0] r_wb_data;
  logic        r_err_align;
  logic        r_err_timeout;

  logic w_idle;
  logic w_access;
  logic w_memop;
  logic w_aligned;
  logic w_newop;
  logic w_misalign;
  logic w_to_halt;
  logic w_stall;

  assign w_idle     = (r_state == IDLE);
  assign w_access   = (r_state == ACCESS);
  assign w_memop    = valid & (dmemREN_l | dmemWEN_l);
  assign w_aligned  = (aluout[1:0] == 2'b00);
  assign w_newop    = w_idle & w_memop & w_aligned;
  assign w_misalign = w_idle & w_memop & ~w_aligned;
  // a memory op in the same slot takes priority over halt
  assign w_to_halt  = w_idle & ~w_newop & valid & hlt_l;
  assign w_cnt_nxt  = (r_wait_cnt == 8'hFF) ? 8'hFF
                    : r_wait_cnt + 8'd1;

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_newop)        w_state_nxt = ACCESS;
        else if (w_to_halt) w_state_nxt = HALTED;
      end
      ACCESS: if (dhit) w_state_nxt = IDLE;
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    dmemREN = w_access & ~r_is_store;
    dmemWEN = w_access & r_is_store;
    w_stall = w_newop | (w_access & ~dhit)
            | (r_state == HALTED);
    halt    = (r_state == HALTED);
  end

  assign mem_stall   = w_stall;
  assign dmemaddr    = r_addr;
  assign dmemstore   = r_sdata;
  assign wb_valid    = r_wb_valid;
  assign wb_regen    = r_wb_regen;
  assign wb_wsel     = r_wb_wsel;
  assign wb_data     = r_wb_data;
  assign err_align   = r_err_align;
  assign err_timeout = r_err_timeout;

  // request latch and wait counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr        <= '0;
      r_sdata       <= '0;
      r_is_store    <= 1'b0;
      r_regen       <= 1'b0;
      r_wsel        <= '0;
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else if (w_newop) begin
      r_addr     <= aluout;
      r_sdata    <= storedata;
      r_is_store <= dmemWEN_l;
      r_regen    <= regen_l;
      r_wsel     <= wsel_l;
      r_wait_cnt <= '0;
    end else if (w_access & ~dhit) begin
      r_wait_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == 8'hFF) r_err_timeout <= 1'b1;
    end
  end

  // MEM/WB register; only advances when the pipe moves
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wb_valid  <= 1'b0;
      r_wb_regen  <= 1'b0;
      r_wb_wsel   <= '0;
      r_wb_data   <= '0;
      r_err_align <= 1'b0;
    end else begin
      if (w_misalign) r_err_align <= 1'b1;
      if (!w_stall) begin
        r_wb_valid <= valid & ~w_to_halt;
        if (w_access & ~r_is_store) begin
          r_wb_data  <= dmemload;
          r_wb_wsel  <= r_wsel;
          r_wb_regen <= r_regen;
        end else begin
          r_wb_data  <= aluout;
          r_wb_wsel  <= wsel_l;
          r_wb_regen <= regen_l & ~w_misalign;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl.
// Drives EX/MEM slots, models the dcache, checks requests and writeback.
module tb_dmem_access_ctrl;

  logic        CLK;
  logic        nRST;
  logic        valid;
  logic        dmemREN_l;
  logic        dmemWEN_l;
  logic [31:0] aluout;
  logic [31:0] storedata;
  logic        hlt_l;
  logic        regen_l;
  logic [4:0]  wsel_l;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_stall;
  logic        wb_valid;
  logic        wb_regen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_data;
  logic        halt;
  logic        err_align;
  logic        err_timeout;

  dmem_access_ctrl dut (
    .CLK(CLK), .nRST(nRST), .valid(valid),
    .dmemREN_l(dmemREN_l), .dmemWEN_l(dmemWEN_l),
    .aluout(aluout), .storedata(storedata),
    .hlt_l(hlt_l), .regen_l(regen_l), .wsel_l(wsel_l),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_regen(wb_regen), .wb_wsel(wb_wsel),
    .wb_data(wb_data), .halt(halt),
    .err_align(err_align), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        v;
    logic        rg;
    logic [4:0]  ws;
    logic [31:0] d;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    valid     = 1'b0;
    dmemREN_l = 1'b0;
    dmemWEN_l = 1'b0;
    aluout    = '0;
    storedata = '0;
    hlt_l     = 1'b0;
    regen_l   = 1'b0;
    wsel_l    = '0;
    dhit      = 1'b0;
    dmemload  = '0;
  endtask

  // present one slot, serve it like a cache with `waits` miss cycles
  task automatic do_op(input string tag,
                       input logic v, input logic ren,
                       input logic wen, input logic [31:0] a,
                       input logic [31:0] sd, input logic hl,
                       input logic rg, input logic [4:0] ws,
                       input int waits, input logic [31:0] ld);
    exp_t e;
    exp_t g;
    logic is_mem;
    logic algn;
    logic st;
    int   stall_n;
    int   req_n;
    int   bad;
    logic s;
    logic done;
    @(negedge CLK);
    valid = v; dmemREN_l = ren; dmemWEN_l = wen;
    aluout = a; storedata = sd; hlt_l = hl;
    regen_l = rg; wsel_l = ws; dmemload = ld;
    dhit = 1'b0;
    is_mem = v & (ren | wen);
    algn   = (a[1:0] == 2'b00);
    st     = wen;
    e.v = v; e.rg = rg; e.ws = ws; e.d = a;
    e.stalls = 0; e.reqs = 0;
    if (is_mem && algn) begin
      e.stalls = waits + 1;
      e.reqs   = waits + 1;
      if (!st) e.d = ld;
    end else if (is_mem) begin
      e.rg = 1'b0;
    end else if (v && hl) begin
      e.v = 1'b0;
    end
    exp_q.push_back(e);
    stall_n = 0; req_n = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (dmemREN || dmemWEN) begin
        req_n++;
        if (dmemaddr !== a || dmemstore !== sd) bad++;
        if (dmemREN !== !st || dmemWEN !== st) bad++;
        if (waits > 250 && req_n == 255)
          chk({tag, "_to_pre"}, 32'(err_timeout), 0);
        if (waits > 250 && req_n == 256)
          chk({tag, "_to_set"}, 32'(err_timeout), 1);
        dhit = (req_n == waits + 1);
      end else begin
        dhit = 1'b0;
      end
      #1;
      s = mem_stall;
      if (s) stall_n++;
      @(posedge CLK);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!done) chk({tag, "_bound"}, 1, 0);
    g = exp_q.pop_front();
    chk({tag, "_stalls"}, stall_n, g.stalls);
    chk({tag, "_reqs"}, req_n, g.reqs);
    chk({tag, "_reqok"}, bad, 0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'(g.v));
    chk({tag, "_wbrg"}, 32'(wb_regen), 32'(g.rg));
    chk({tag, "_wbws"}, 32'(wb_wsel), 32'(g.ws));
    chk({tag, "_wbd"}, wb_data, g.d);
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;
    idle_in();
    nRST = 1'b0;
    #3;
    chk("rst_ren", 32'(dmemREN | dmemWEN), 0);
    chk("rst_addr", dmemaddr | dmemstore, 0);
    chk("rst_wb", {wb_valid, wb_regen, wb_wsel} | wb_data, 0);
    chk("rst_flags", {halt, err_align, err_timeout, mem_stall}, 0);
    @(negedge CLK);
    nRST = 1'b1;

    do_op("ld_hit", 1, 1, 0, 32'h100, 32'h0, 0, 1, 5, 0, 32'hCAFE0001);
    do_op("st_miss", 1, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, 0, 2, 32'h0);
    do_op("alu", 1, 0, 0, 32'h1234, 32'h0, 0, 1, 7, 0, 32'h0);
    do_op("both", 1, 1, 1, 32'h44, 32'h5555AAAA, 0, 0, 3, 1, 32'h0);
    do_op("ld_w3", 1, 1, 0, 32'h80, 32'h1, 0, 1, 9, 3, 32'h12345678);
    do_op("novalid", 0, 1, 0, 32'h90, 32'h0, 0, 1, 4, 0, 32'h0);
    chk("align_pre", 32'(err_align), 0);
    do_op("misal", 1, 1, 0, 32'h102, 32'h0, 0, 1, 6, 0, 32'h77);
    chk("align_set", 32'(err_align), 1);

    for (int i = 0; i < 6; i++) begin
      kind = int'($urandom_range(0, 2));
      ra = $urandom & 32'hFFFF_FFFC;
      do_op("rnd", 1, kind == 0, kind == 1, ra, $urandom,
            0, kind != 1, 5'($urandom_range(1, 31)),
            int'($urandom_range(0, 4)), $urandom);
    end

    chk("to_pre0", 32'(err_timeout), 0);
    do_op("tmo", 1, 1, 0, 32'h400, 32'h0, 0, 1, 12, 259, 32'hA5A5A5A5);
    chk("to_sticky", 32'(err_timeout), 1);

    // reset in the second ACCESS cycle
    @(negedge CLK);
    valid = 1; dmemREN_l = 1; aluout = 32'h2F0;
    regen_l = 1; wsel_l = 8; dhit = 0;
    @(negedge CLK);
    chk("mid_req", 32'(dmemREN), 1);
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_ren", 32'(dmemREN | dmemWEN), 0);
    chk("mid_addr", dmemaddr | dmemstore, 0);
    chk("mid_wb", {wb_valid, wb_regen, wb_wsel} | wb_data, 0);
    chk("mid_flags", {halt, err_align, err_timeout}, 0);
    chk("mid_stall", 32'(mem_stall), 1);
    idle_in();
    @(negedge CLK);
    nRST = 1'b1;
    do_op("post_rst", 1, 1, 0, 32'h300, 32'h0, 0, 1, 5, 0, 32'hBEEF0300);

    do_op("halt", 1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      valid = 1; dmemREN_l = 1; aluout = 32'h500;
      dhit = i[0];
      #1;
      chk("h_halt", 32'(halt), 1);
      chk("h_stall", 32'(mem_stall), 1);
      chk("h_req", 32'(dmemREN | dmemWEN), 0);
      chk("h_wbv", 32'(wb_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
